inst_fetch_stage: RTL and testbench
===================================

# inst_fetch_stage

Instruction-fetch stage of the 5-stage RISC-V pipeline, directly upstream of the read-only instruction cache. Owns the program counter, drives the cache word address, and captures returned words into the IF/ID pipeline register. Also handles cache-miss stalls, ID-stage hazard holds and EX-stage redirects (branch/jump). PC never changes while the cache reports a miss, so the cache sees a stable address for its whole refill.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC at reset; word aligned.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- icache_read  out  1  constant 1 while rst_n=1
- icache_write  out  1  constant 0
- icache_addr  out  30  word address = pc[31:2], direct from PC register
- icache_rdata  in  32  fetched word, valid same cycle when icache_stall=0
- icache_stall  in  1  cache miss/refill in progress
- id_stall  in  1  ID hazard: hold IF/ID and PC
- redirect_valid  in  1  EX redirect request, single-cycle pulse
- redirect_pc  in  32  redirect target, word aligned
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_pc  out  32  PC of the instruction in IF/ID
- ifid_inst  out  32  byte-swapped word {rdata[7:0],rdata[15:8],rdata[23:16],rdata[31:24]}

## Operation

- Registers: pc[31:0], pend_pc[31:0], state (RUN, MISS, DRAIN), ifid_valid, ifid_pc, ifid_inst.
- Reset (async, rst_n=0): pc=RESET_PC, pend_pc=0, state=RUN, ifid_valid=0, ifid_pc=0, ifid_inst=0. icache_read=0 during reset.
- Capture: ifid_valid<=1, ifid_pc<=pc, ifid_inst<=swap(icache_rdata), pc<=pc+4. The PC adder wraps modulo 2^32.
- Bubble: ifid_valid<=0, ifid_pc and ifid_inst held.
- RUN:
  - redirect_valid & !icache_stall: pc<=redirect_pc, ifid_valid<=0 even if id_stall=1; stay RUN.
  - redirect_valid & icache_stall: pend_pc<=redirect_pc, ifid_valid<=0, pc held; go DRAIN.
  - icache_stall: pc held; go MISS. Bubble if !id_stall, else IF/ID held.
  - id_stall: pc and IF/ID held.
  - otherwise: Capture.
- MISS:
  - redirect_valid & icache_stall: pend_pc<=redirect_pc, ifid_valid<=0; go DRAIN.
  - redirect_valid & !icache_stall: pc<=redirect_pc, ifid_valid<=0; go RUN. The returned word is discarded.
  - icache_stall: stay MISS, pc held. Bubble if !id_stall, else IF/ID held.
  - !icache_stall & id_stall: go RUN with pc and IF/ID held. The word hits next cycle.
  - !icache_stall & !id_stall: Capture; go RUN.
- DRAIN (wrong-path refill completing):
  - redirect_valid: pend_pc<=redirect_pc (latest redirect wins).
  - icache_stall=1: hold pc, ifid_valid=0.
  - icache_stall=0: pc<=(redirect_valid ? redirect_pc : pend_pc), ifid_valid=0, word discarded; go RUN.
- Redirect has priority over id_stall. The instruction sitting in ID is wrong-path by definition.
- Invariant: pc (and icache_addr) is constant during every cycle in which icache_stall=1.

## Timing

- Hit throughput: 1 instruction/cycle. The address-to-rdata path is combinational through the cache. IF/ID updates on the edge after icache_rdata is valid.
- Miss: IF/ID shows bubbles for every icache_stall cycle. The first capture happens on the first edge with icache_stall=0 and id_stall=0.
- Redirect penalty: exactly 1 bubble when the cache hits on the target. On a miss, add the cache refill time.
- Redirect during a miss: the target is fetched starting the cycle after icache_stall falls. No instruction from the old miss address ever reaches IF/ID with valid=1.
- rst_n asserted mid-miss: all registers return to reset values immediately. The next fetch is at RESET_PC.

## Test plan

- Reset, RESET_PC=0, cache always hits with rdata=0x13000000 -> after reset: icache_addr=0, 1, 2…; ifid_inst=0x00000013, ifid_pc=0, 4, 8 on consecutive cycles.
- icache_stall=1 for 5 cycles at pc=0x40 -> icache_addr held at 0x10 all 5 cycles; 5 bubbles; next edge: ifid_pc=0x40, pc=0x44.
- redirect_valid to 0x100 in RUN with hit -> next cycle ifid_valid=0, icache_addr=0x40; the following cycle ifid_pc=0x100.
- redirect to 0x200 on the 2nd cycle of a 6-cycle miss at 0x80 -> icache_addr stays 0x20 until stall drops; then icache_addr=0x80; 0x80 is never captured valid; first valid ifid_pc=0x200.
- id_stall=1 for 3 cycles in RUN -> pc and IF/ID frozen 3 cycles, then capture resumes with no skipped or duplicated PC.
- rst_n low for 1 cycle during MISS -> ifid_valid=0 and pc=RESET_PC immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the I-cache word address, fills IF/ID.
// Latency: one cycle from icache_rdata valid to IF/ID valid; 1 instr/cycle on hits.
// Backpressure: icache_stall and id_stall freeze the PC; redirects override id_stall.
module inst_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic        o_icache_read,
   output logic        o_icache_write,
   output logic [29:0] o_icache_addr,
   input  logic [31:0] i_icache_rdata,
   input  logic        i_icache_stall,
   input  logic        i_id_stall,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_pc,
   output logic        o_ifid_valid,
   output logic [31:0] o_ifid_pc,
   output logic [31:0] o_ifid_inst
);

   // RUN: normal fetch; MISS: waiting on refill of the current PC;
   // DRAIN: waiting on a refill whose word is wrong-path and will be dropped.
   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_MISS  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_pend_pc;
   logic        r_ifid_valid;
   logic [31:0] r_ifid_pc;
   logic [31:0] r_ifid_inst;

   logic [31:0] w_pc_inc;
   logic [31:0] w_inst_swap;

   // Sequential PC increment wraps naturally at 2^32.
   assign w_pc_inc    = r_pc + 32'd4;
   // Cache returns words byte-reversed relative to instruction order.
   assign w_inst_swap = {i_icache_rdata[7:0],   i_icache_rdata[15:8],
                         i_icache_rdata[23:16], i_icache_rdata[31:24]};

   // Reads are requested continuously whenever the block is out of reset.
   assign o_icache_read  = i_rst_n;
   assign o_icache_write = 1'b0;
   assign o_icache_addr  = r_pc[31:2];
   assign o_ifid_valid   = r_ifid_valid;
   assign o_ifid_pc      = r_ifid_pc;
   assign o_ifid_inst    = r_ifid_inst;

   // Fetch FSM: PC, pending redirect target and IF/ID register all updated here.
   // The PC is only written on cycles with icache_stall=0, keeping the cache address stable during refills.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_RUN;
         r_pc         <= RESET_PC;
         r_pend_pc    <= 32'd0;
         r_ifid_valid <= 1'b0;
         r_ifid_pc    <= 32'd0;
         r_ifid_inst  <= 32'd0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (i_redirect_valid && !i_icache_stall) begin
                  r_pc         <= i_redirect_pc;
                  r_ifid_valid <= 1'b0;
               end else if (i_redirect_valid) begin
                  r_pend_pc    <= i_redirect_pc;
                  r_ifid_valid <= 1'b0;
                  r_state      <= S_DRAIN;
               end else if (i_icache_stall) begin
                  r_state <= S_MISS;
                  if (!i_id_stall) begin
                     r_ifid_valid <= 1'b0;
                  end
               end else if (!i_id_stall) begin
                  r_ifid_valid <= 1'b1;
                  r_ifid_pc    <= r_pc;
                  r_ifid_inst  <= w_inst_swap;
                  r_pc         <= w_pc_inc;
               end
            end
            S_MISS: begin
               if (i_redirect_valid && i_icache_stall) begin
                  r_pend_pc    <= i_redirect_pc;
                  r_ifid_valid <= 1'b0;
                  r_state      <= S_DRAIN;
               end else if (i_redirect_valid) begin
                  // Refill finished on the old path; its word is dropped.
                  r_pc         <= i_redirect_pc;
                  r_ifid_valid <= 1'b0;
                  r_state      <= S_RUN;
               end else if (i_icache_stall) begin
                  if (!i_id_stall) begin
                     r_ifid_valid <= 1'b0;
                  end
               end else if (i_id_stall) begin
                  // Line is now resident; the same PC hits again next cycle.
                  r_state <= S_RUN;
               end else begin
                  r_ifid_valid <= 1'b1;
                  r_ifid_pc    <= r_pc;
                  r_ifid_inst  <= w_inst_swap;
                  r_pc         <= w_pc_inc;
                  r_state      <= S_RUN;
               end
            end
            S_DRAIN: begin
               r_ifid_valid <= 1'b0;
               if (i_redirect_valid) begin
                  r_pend_pc <= i_redirect_pc;
               end
               if (!i_icache_stall) begin
                  r_pc    <= i_redirect_valid ? i_redirect_pc : r_pend_pc;
                  r_state <= S_RUN;
               end
            end
            default: begin
               r_state <= S_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Bench for inst_fetch_stage: directed fetch/stall/redirect/reset sequences.
// Expected IF/ID contents are queued as stimulus is issued and popped by a monitor.
// An instruction counts as consumed on a falling edge with valid=1 and id_stall=0.
module tb_inst_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        icache_read;
   logic        icache_write;
   logic [29:0] icache_addr;
   logic [31:0] icache_rdata;
   logic        icache_stall;
   logic        id_stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        ifid_valid;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_inst;

   int          n_chk;
   int          n_fail;
   logic        mode;
   logic [63:0] sb_q[$];
   logic [63:0] exp_e;

   inst_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .o_icache_read    (icache_read),
      .o_icache_write   (icache_write),
      .o_icache_addr    (icache_addr),
      .i_icache_rdata   (icache_rdata),
      .i_icache_stall   (icache_stall),
      .i_id_stall       (id_stall),
      .i_redirect_valid (redirect_valid),
      .i_redirect_pc    (redirect_pc),
      .o_ifid_valid     (ifid_valid),
      .o_ifid_pc        (ifid_pc),
      .o_ifid_inst      (ifid_inst)
   );

   // Cache model: mode 0 returns a fixed NOP image, mode 1 returns the low address byte.
   assign icache_rdata = mode ? {24'h0, icache_addr[7:0]} : 32'h1300_0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] inst);
      sb_q.push_back({pc, inst});
   endtask

   // Monitor: every consumed IF/ID entry must match the next queued expectation.
   always @(negedge clk) begin
      if (rst_n && ifid_valid && !id_stall) begin
         n_chk++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got pc %0h inst %0h expected nothing", ifid_pc, ifid_inst);
         end else begin
            exp_e = sb_q.pop_front();
            if ({ifid_pc, ifid_inst} !== exp_e) begin
               n_fail++;
               $display("FAIL sb_ifid: got pc %0h inst %0h expected pc %0h inst %0h",
                        ifid_pc, ifid_inst, exp_e[63:32], exp_e[31:0]);
            end
         end
      end
   end

   initial begin
      n_chk          = 0;
      n_fail         = 0;
      mode           = 1'b0;
      rst_n          = 1'b0;
      icache_stall   = 1'b0;
      id_stall       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;

      // Reset state
      #2;
      chk("rst_valid", ifid_valid, 0);
      chk("rst_read", icache_read, 0);
      chk("rst_write", icache_write, 0);
      chk("rst_addr", icache_addr, 0);
      chk("rst_ifid_pc", ifid_pc, 0);
      chk("rst_ifid_inst", ifid_inst, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("read_after_rst", icache_read, 1);

      // Streaming hits with the constant NOP image
      for (int i = 0; i < 4; i++) begin
         chk("stream_addr_pre", icache_addr, i);
         push(i * 4, 32'h0000_0013);
         step();
         chk("stream_addr_post", icache_addr, i + 1);
      end

      // Redirect in RUN with a hit: one bubble, then the target
      mode           = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      step();
      redirect_valid = 1'b0;
      chk("redir_bubble", ifid_valid, 0);
      chk("redir_addr", icache_addr, 30'h40);
      push(32'h100, 32'h4000_0000);
      step();
      chk("redir_ifid_pc", ifid_pc, 32'h100);
      push(32'h104, 32'h4100_0000);
      step();

      // ID hold for 3 cycles
      id_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idst_addr", icache_addr, 30'h42);
         chk("idst_ifid_pc", ifid_pc, 32'h104);
         chk("idst_valid", ifid_valid, 1);
      end
      id_stall = 1'b0;
      push(32'h108, 32'h4200_0000);
      step();
      chk("idst_resume_pc", ifid_pc, 32'h108);

      // 5-cycle miss at 0x40
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      step();
      redirect_valid = 1'b0;
      icache_stall   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("miss_addr", icache_addr, 30'h10);
         chk("miss_bubble", ifid_valid, 0);
      end
      icache_stall = 1'b0;
      push(32'h40, 32'h1000_0000);
      step();
      chk("miss_pc_next", icache_addr, 30'h11);

      // Redirect to 0x200 on the 2nd cycle of a 6-cycle miss at 0x80
      redirect_valid = 1'b1;
      redirect_pc    = 32'h80;
      step();
      redirect_valid = 1'b0;
      icache_stall   = 1'b1;
      step();
      chk("drain_addr_c1", icache_addr, 30'h20);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      step();
      redirect_valid = 1'b0;
      chk("drain_addr_c2", icache_addr, 30'h20);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("drain_addr", icache_addr, 30'h20);
         chk("drain_bubble", ifid_valid, 0);
      end
      icache_stall = 1'b0;
      step();
      chk("drain_target_addr", icache_addr, 30'h80);
      chk("drain_no_old_word", ifid_valid, 0);
      push(32'h200, 32'h8000_0000);
      step();
      push(32'h204, 32'h8100_0000);
      step();
      chk("drain_seq_addr", icache_addr, 30'h82);

      // PC wrap at the top of the address space
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      chk("wrap_addr_top", icache_addr, 30'h3FFF_FFFF);
      push(32'hFFFF_FFFC, 32'hFF00_0000);
      step();
      chk("wrap_addr_zero", icache_addr, 0);
      push(32'h0, 32'h0000_0000);
      step();
      chk("wrap_addr_one", icache_addr, 1);

      // Reset asserted for one cycle in the middle of a miss
      icache_stall = 1'b1;
      step();
      step();
      chk("rmiss_addr", icache_addr, 1);
      rst_n = 1'b0;
      #1;
      chk("rmiss_valid", ifid_valid, 0);
      chk("rmiss_addr_rst", icache_addr, 0);
      chk("rmiss_read", icache_read, 0);
      chk("rmiss_ifid_pc", ifid_pc, 0);
      step();
      rst_n        = 1'b1;
      icache_stall = 1'b0;
      push(32'h0, 32'h0000_0000);
      step();
      push(32'h4, 32'h0100_0000);
      step();
      chk("rmiss_restart_addr", icache_addr, 2);

      icache_stall = 1'b1;
      step();
      step();
      chk("sb_drained", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
